// File: rtl/vga_pixel_renderer.sv
`default_nettype none
// ============================================================================
// Module   : vga_pixel_renderer
// Purpose  : Pixel back-end for a cell-based VGA playfield. Consumes the sync
//            generator's position, display flag and syncs. Drives the cell
//            colour and the delayed syncs to the pins with a fixed latency of
//            two clocks. The playfield is double buffered. Game logic writes
//            cells into the back buffer. The front and back buffers exchange
//            roles only at a frame boundary. A sequential clear wipes the back
//            buffer one cell per clock.
// Ports    : clk, rst_n            clock / asynchronous active-low reset
//            i_count_x/i_count_y   position from sync generator (cell units)
//            i_in_display          display-area flag
//            i_hsync_in/i_vsync_in syncs from generator (active low)
//            i_wr_en/x/y/color     back-buffer cell write
//            o_wr_err              1-cycle pulse, write rejected
//            i_clr / o_clr_busy    start back-buffer clear / clear running
//            i_swap_req/o_swap_ack level swap request / 1-cycle ack
//            o_frame_start         1-cycle pulse after position (0,0) sampled
//            o_rgb                 pixel colour
//            o_hsync_out/o_vsync_out syncs delayed by two clocks
// Revision : 1.0  initial release
// ============================================================================
module vga_pixel_renderer #(
    parameter int COLS    = 10,
    parameter int ROWS    = 20,
    parameter int COLOR_W = 3,
    parameter int BLANK   = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [9:0]         i_count_x,
    input  logic [9:0]         i_count_y,
    input  logic               i_in_display,
    input  logic               i_hsync_in,
    input  logic               i_vsync_in,
    input  logic               i_wr_en,
    input  logic [3:0]         i_wr_x,
    input  logic [4:0]         i_wr_y,
    input  logic [COLOR_W-1:0] i_wr_color,
    output logic               o_wr_err,
    input  logic               i_clr,
    output logic               o_clr_busy,
    input  logic               i_swap_req,
    output logic               o_swap_ack,
    output logic               o_frame_start,
    output logic [COLOR_W-1:0] o_rgb,
    output logic               o_hsync_out,
    output logic               o_vsync_out
);

    localparam int                   c_CELLS   = COLS * ROWS;
    localparam int                   c_CELL_AW = $clog2(c_CELLS);
    localparam logic [c_CELL_AW-1:0] c_LAST    = c_CELL_AW'(c_CELLS - 1);
    localparam logic [COLOR_W-1:0]   c_BLANK   = COLOR_W'(BLANK);
    localparam logic [3:0]           c_COLS_WX = 4'(COLS);
    localparam logic [4:0]           c_ROWS_WY = 5'(ROWS);
    localparam logic [9:0]           c_COLS_CX = 10'(COLS);
    localparam logic [9:0]           c_ROWS_CY = 10'(ROWS);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Control state
    // ------------------------------------------------------------------
    state_t               r_state;
    logic [c_CELL_AW-1:0] r_clr_idx;
    logic                 r_front_sel;
    logic                 r_clr_busy;
    logic                 r_swap_ack;
    logic                 r_wr_err;
    logic                 r_frame_start;

    // Pixel pipeline
    logic                 r_pix_vld_d1;
    logic                 r_hs_d1;
    logic                 r_vs_d1;
    logic [COLOR_W-1:0]   r_rd_cell;
    logic [COLOR_W-1:0]   r_rgb;
    logic                 r_hs_d2;
    logic                 r_vs_d2;

    // Playfield storage: first index selects the buffer, second the cell.
    // Not reset; a clear must be issued before the contents are meaningful.
    logic [COLOR_W-1:0]   r_mem [2][c_CELLS];

    logic                 w_frame;
    logic                 w_idle;
    logic                 w_wr_ok;
    logic                 w_swap;
    logic                 w_back;
    logic                 w_rd_in_pf;
    logic [c_CELL_AW-1:0] w_rd_idx;
    logic [c_CELL_AW-1:0] w_wr_idx;

    assign w_frame    = (i_count_x == 10'd0) && (i_count_y == 10'd0);
    assign w_idle     = (r_state == ST_IDLE);
    assign w_wr_ok    = i_wr_en && (i_wr_x < c_COLS_WX) && (i_wr_y < c_ROWS_WY) && w_idle;
    // A clear cannot overlap a swap; a request seen during a clear simply
    // waits for the next frame boundary after the clear finishes.
    assign w_swap     = w_frame && i_swap_req && w_idle;
    assign w_back     = ~r_front_sel;
    assign w_rd_in_pf = (i_count_x < c_COLS_CX) && (i_count_y < c_ROWS_CY);
    // Off-playfield positions read cell 0; the result is masked to BLANK later.
    assign w_rd_idx   = w_rd_in_pf ? c_CELL_AW'(int'(i_count_y) * COLS + int'(i_count_x))
                                   : '0;
    assign w_wr_idx   = c_CELL_AW'(int'(i_wr_y) * COLS + int'(i_wr_x));

    // ------------------------------------------------------------------
    // Playfield RAM: one write port (game write or clear), one read port.
    // Both use the buffer select before any swap taken at this edge, so a
    // write coinciding with a swap lands in the buffer becoming the front.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_wr_ok) begin
            r_mem[w_back][w_wr_idx] <= i_wr_color;
        end else if (r_state == ST_CLEAR) begin
            r_mem[w_back][r_clr_idx] <= '0;
        end
        r_rd_cell <= r_mem[r_front_sel][w_rd_idx];
    end

    // ------------------------------------------------------------------
    // Control FSM: clear sequencing, buffer swap and status pulses.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_clr_idx     <= '0;
            r_front_sel   <= 1'b0;
            r_clr_busy    <= 1'b0;
            r_swap_ack    <= 1'b0;
            r_wr_err      <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_wr_err      <= i_wr_en && !w_wr_ok;
            r_frame_start <= w_frame;
            r_swap_ack    <= w_swap;
            if (w_swap) begin
                r_front_sel <= ~r_front_sel;
            end
            case (r_state)
                ST_IDLE: begin
                    // A clear started together with a swap runs on the new
                    // back buffer, since its first write is one clock later.
                    if (i_clr) begin
                        r_state    <= ST_CLEAR;
                        r_clr_idx  <= '0;
                        r_clr_busy <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    if (r_clr_idx == c_LAST) begin
                        r_state    <= ST_IDLE;
                        r_clr_busy <= 1'b0;
                    end else begin
                        r_clr_idx <= r_clr_idx + c_CELL_AW'(1);
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_clr_busy <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Pixel pipeline: stage 1 aligns the sampled flags with the RAM read,
    // stage 2 selects cell colour or BLANK.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pix_vld_d1 <= 1'b0;
            r_hs_d1      <= 1'b1;
            r_vs_d1      <= 1'b1;
            r_rgb        <= c_BLANK;
            r_hs_d2      <= 1'b1;
            r_vs_d2      <= 1'b1;
        end else begin
            r_pix_vld_d1 <= i_in_display && w_rd_in_pf;
            r_hs_d1      <= i_hsync_in;
            r_vs_d1      <= i_vsync_in;
            r_rgb        <= r_pix_vld_d1 ? r_rd_cell : c_BLANK;
            r_hs_d2      <= r_hs_d1;
            r_vs_d2      <= r_vs_d1;
        end
    end

    assign o_wr_err      = r_wr_err;
    assign o_clr_busy    = r_clr_busy;
    assign o_swap_ack    = r_swap_ack;
    assign o_frame_start = r_frame_start;
    assign o_rgb         = r_rgb;
    assign o_hsync_out   = r_hs_d2;
    assign o_vsync_out   = r_vs_d2;

endmodule
`default_nettype wire
